// File: rtl/menu_option_editor.sv
// rtl/menu_option_editor.sv - menu navigation and per-option value editor; AUTO_REPEAT_EN adds held-button auto-repeat
module menu_option_editor #(
    parameter int                          NUM_OPTS   = 3,
    parameter int                          VALUE_W    = 5,
    parameter int                          DIGITS     = 2,
    parameter logic [NUM_OPTS*VALUE_W-1:0] INIT_VALS  = '0,
    parameter int                          REPEAT_DLY = 250000,
    parameter int                          REPEAT_PER = 50000
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_btn_up,
    input  logic                                          i_btn_down,
    input  logic                                          i_btn_left,
    input  logic                                          i_btn_right,
    input  logic                                          i_btn_enter,
    input  logic                                          i_btn_held_up,
    input  logic                                          i_btn_held_down,
    input  logic [NUM_OPTS*VALUE_W-1:0]                   i_opt_min,
    input  logic [NUM_OPTS*VALUE_W-1:0]                   i_opt_max,
    input  logic [NUM_OPTS-1:0]                           i_opt_roll,
    output logic [$clog2(NUM_OPTS+1)-1:0]                 o_sel,
    output logic                                          o_in_sub,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] o_sub_digit,
    output logic [NUM_OPTS*VALUE_W-1:0]                   o_values,
    output logic                                          o_back,
    output logic                                          o_changed
);
    localparam int SEL_W = $clog2(NUM_OPTS + 1);
    localparam int SD_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW1   = VALUE_W + 1;

    logic [SEL_W-1:0]   r_sel;
    logic               r_in_sub;
    logic [SD_W-1:0]    r_sub_digit;
    logic [VALUE_W-1:0] r_vals [NUM_OPTS];
    logic               r_back;
    logic               r_changed;
    logic               w_up;
    logic               w_down;

`ifdef AUTO_REPEAT_EN
    localparam int RC_W = $clog2(REPEAT_DLY + 1);

    // Counter is 0 when idle; an edge pulse arms it, a synthetic press fires at REPEAT_DLY.
    logic [RC_W-1:0] r_rep_up;
    logic [RC_W-1:0] r_rep_dn;
    logic            w_syn_up;
    logic            w_syn_dn;

    assign w_syn_up = i_btn_held_up & ~i_btn_held_down & (r_rep_up == RC_W'(REPEAT_DLY));
    assign w_syn_dn = i_btn_held_down & ~i_btn_held_up & (r_rep_dn == RC_W'(REPEAT_DLY));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rep_up <= '0;
            r_rep_dn <= '0;
        end else begin
            if (!i_btn_held_up || i_btn_held_down) r_rep_up <= '0;
            else if (i_btn_up)                     r_rep_up <= RC_W'(1);
            else if (w_syn_up)                     r_rep_up <= RC_W'(REPEAT_DLY - REPEAT_PER + 1);
            else if (r_rep_up != '0)               r_rep_up <= r_rep_up + RC_W'(1);

            if (!i_btn_held_down || i_btn_held_up) r_rep_dn <= '0;
            else if (i_btn_down)                   r_rep_dn <= RC_W'(1);
            else if (w_syn_dn)                     r_rep_dn <= RC_W'(REPEAT_DLY - REPEAT_PER + 1);
            else if (r_rep_dn != '0)               r_rep_dn <= r_rep_dn + RC_W'(1);
        end
    end

    assign w_up   = i_btn_up | w_syn_up;
    assign w_down = i_btn_down | w_syn_dn;
`else
    logic w_unused;
    assign w_unused = ^{i_btn_held_up, i_btn_held_down, REPEAT_DLY[0], REPEAT_PER[0]};
    assign w_up     = i_btn_up;
    assign w_down   = i_btn_down;
`endif

    logic w_ud_up, w_ud_dn, w_lr_r, w_lr_l;
    assign w_ud_up = w_up & ~w_down;
    assign w_ud_dn = w_down & ~w_up;
    assign w_lr_r  = i_btn_right & ~i_btn_left;
    assign w_lr_l  = i_btn_left & ~i_btn_right;

    logic [VALUE_W-1:0] w_cur, w_min, w_max;
    logic               w_roll;
    always_comb begin
        w_cur  = '0;
        w_min  = '0;
        w_max  = '0;
        w_roll = 1'b0;
        for (int k = 0; k < NUM_OPTS; k++) begin
            if (r_sel == SEL_W'(k + 1)) begin
                w_cur  = r_vals[k];
                w_min  = i_opt_min[k*VALUE_W +: VALUE_W];
                w_max  = i_opt_max[k*VALUE_W +: VALUE_W];
                w_roll = i_opt_roll[k];
            end
        end
    end

    // step = 10^(DIGITS-1-sub_digit)
    logic [VW1-1:0] w_step;
    always_comb begin
        w_step = VW1'(1);
        for (int d = 0; d < DIGITS - 1; d++) begin
            if (SD_W'(d) >= r_sub_digit) w_step = w_step * VW1'(10);
        end
    end

    // One extra bit keeps v+step and the limit differences from wrapping.
    logic [VW1-1:0] w_v, w_mn, w_mx, w_add, w_sub, w_inc, w_dec;
    assign w_v   = {1'b0, w_cur};
    assign w_mn  = {1'b0, w_min};
    assign w_mx  = {1'b0, w_max};
    assign w_add = (w_v >= w_mx || w_step >= w_mx - w_v) ? w_mx : w_v + w_step;
    assign w_sub = (w_v <= w_mn || w_v - w_mn <= w_step) ? w_mn : w_v - w_step;
    assign w_inc = (w_v >= w_mx) ? (w_roll ? w_mn : w_mx) : w_v + VW1'(1);
    assign w_dec = (w_v <= w_mn) ? (w_roll ? w_mx : w_mn) : w_v - VW1'(1);

    logic           w_wr;
    logic [VW1-1:0] w_new;
    always_comb begin
        w_wr  = 1'b0;
        w_new = w_v;
        if (!i_btn_enter) begin
            if (w_ud_up || w_ud_dn) begin
                if (r_in_sub) begin
                    w_wr  = 1'b1;
                    w_new = w_ud_up ? w_add : w_sub;
                end
            end else if ((w_lr_r || w_lr_l) && !r_in_sub && r_sel != '0) begin
                w_wr  = 1'b1;
                w_new = w_lr_r ? w_inc : w_dec;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel       <= '0;
            r_in_sub    <= 1'b0;
            r_sub_digit <= '0;
            r_back      <= 1'b0;
            r_changed   <= 1'b0;
            for (int k = 0; k < NUM_OPTS; k++) r_vals[k] <= INIT_VALS[k*VALUE_W +: VALUE_W];
        end else begin
            r_back    <= 1'b0;
            r_changed <= w_wr && (w_new != w_v);
            if (w_wr) begin
                for (int k = 0; k < NUM_OPTS; k++) begin
                    if (r_sel == SEL_W'(k + 1)) r_vals[k] <= w_new[VALUE_W-1:0];
                end
            end
            if (i_btn_enter) begin
                if (r_in_sub) begin
                    r_in_sub    <= 1'b0;
                    r_sub_digit <= '0;
                end else if (r_sel == '0) begin
                    r_back <= 1'b1;
                end else begin
                    r_in_sub    <= 1'b1;
                    r_sub_digit <= '0;
                end
            end else if (w_ud_up || w_ud_dn) begin
                if (!r_in_sub) begin
                    if (w_ud_up && r_sel != '0)                    r_sel <= r_sel - SEL_W'(1);
                    else if (w_ud_dn && r_sel != SEL_W'(NUM_OPTS)) r_sel <= r_sel + SEL_W'(1);
                end
            end else if (r_in_sub) begin
                if (w_lr_r)
                    r_sub_digit <= (r_sub_digit == SD_W'(DIGITS - 1)) ? '0 : r_sub_digit + SD_W'(1);
                else if (w_lr_l)
                    r_sub_digit <= (r_sub_digit == '0) ? SD_W'(DIGITS - 1) : r_sub_digit - SD_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_OPTS; k++) begin : g_out
        assign o_values[k*VALUE_W +: VALUE_W] = r_vals[k];
    end

    assign o_sel       = r_sel;
    assign o_in_sub    = r_in_sub;
    assign o_sub_digit = r_sub_digit;
    assign o_back      = r_back;
    assign o_changed   = r_changed;

endmodule
